// File: rtl/apb_master_pkg.sv
// Shared types for the APB master bridge: FSM state encoding and the response payload.
package apb_master_pkg;

  // Response payload width; the bridge DATA_WIDTH must not exceed it.
  localparam int unsigned RSP_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic [RSP_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } rsp_t;

  localparam rsp_t RSP_CLEAR   = '{rdata: '0, err: 1'b0, timeout: 1'b0};
  localparam rsp_t RSP_TIMEOUT = '{rdata: '0, err: 1'b1, timeout: 1'b1};

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response handshake plus APB bus signals of the bridge.
// master = bridge view, slave = requester/APB-peer view.
interface apb_master_bridge_if
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = RSP_DATA_W
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;
  logic                  pready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  prdata, pslverr, pready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output prdata, pslverr, pready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_wait_timer.sv
// Counts consecutive ACCESS cycles with pready low; expired_c flags the cycle
// that is the TIMEOUT_CYCLES-th such cycle, so the FSM can abort at its end.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_c
);
  localparam int unsigned      CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired_c = enable_i && (cnt_q == LAST);

  // Saturate at LAST; the bridge leaves ACCESS on expiry and clears on the next accept.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/apb_master_bridge.sv
// APB master bridge: runs one command as an APB SETUP/ACCESS transfer and returns
// a held response; a stalled slave is aborted after TIMEOUT_CYCLES wait cycles.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = RSP_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic                 pclk,
  input logic                 preset,
  apb_master_bridge_if.master bus
);
  state_e                state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  rsp_t                  rsp_q, rsp_d;
  logic                  accept_c;
  logic                  wait_en_c;
  logic                  expired_c;

  assign accept_c  = (state_q == ST_IDLE) && bus.cmd_valid;
  assign wait_en_c = (state_q == ST_ACCESS) && !bus.pready;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_i    (pclk),
    .rst_i    (preset),
    .clear_i  (accept_c),
    .enable_i (wait_en_c),
    .expired_c(expired_c)
  );

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= RSP_CLEAR;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.cmd_valid) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (bus.pready || expired_c) state_d = ST_RESP;
      ST_RESP:   if (bus.rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next-cycle values of the registered outputs, decoded from the next state.
  always_comb begin
    psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d   = (state_d == ST_ACCESS);
    rsp_valid_d = (state_d == ST_RESP);
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_d       = rsp_q;
    if (accept_c) begin
      pwrite_d = bus.cmd_write;
      paddr_d  = bus.cmd_addr;
      pwdata_d = bus.cmd_wdata;
    end
    if (state_q == ST_ACCESS) begin
      if (bus.pready) begin
        rsp_d.rdata   = pwrite_q ? '0 : RSP_DATA_W'(bus.prdata);
        rsp_d.err     = bus.pslverr;
        rsp_d.timeout = 1'b0;
      end else if (expired_c) begin
        rsp_d = RSP_TIMEOUT;
      end
    end
  end

  assign bus.cmd_ready   = (state_q == ST_IDLE);
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = DATA_WIDTH'(rsp_q.rdata);
  assign bus.rsp_err     = rsp_q.err;
  assign bus.rsp_timeout = rsp_q.timeout;
endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum ACCESS cycles with pready low before abort (minimum 1).
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have these ports:
  pclk  in  1  clock
  preset  in  1  synchronous active-high reset
  cmd_valid  in  1  command request
  cmd_ready  out  1  command accepted this cycle when high with cmd_valid
  cmd_write  in  1  1=write, 0=read
  cmd_addr  in  ADDR_WIDTH  target address
  cmd_wdata  in  DATA_WIDTH  write data
  rsp_valid  out  1  response available
  rsp_ready  in  1  response consumed
  rsp_rdata  out  DATA_WIDTH  read data (0 for writes and aborts)
  rsp_err  out  1  slave error or timeout
  rsp_timeout  out  1  transfer aborted by timeout
  psel  out  1  APB select
  penable  out  1  APB enable
  pwrite  out  1  APB direction
  paddr  out  ADDR_WIDTH  APB address
  pwdata  out  DATA_WIDTH  APB write data
  prdata  in  DATA_WIDTH  APB read data
  pslverr  in  1  APB slave error
  pready  in  1  APB ready

Function
REQ-006 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-007 SHALL drive cmd_ready high only in IDLE, combinationally from state.
REQ-008 On cmd_valid && cmd_ready, SHALL register cmd_write/addr/wdata into pwrite/paddr/pwdata and go to SETUP.
REQ-009 In SETUP, SHALL drive psel=1 and penable=0 for exactly one cycle, then go to ACCESS.
REQ-010 In ACCESS, SHALL drive psel=1 and penable=1, holding paddr/pwrite/pwdata stable.
REQ-011 In ACCESS with pready=1, SHALL capture prdata (reads only, else 0) into rsp_rdata, set rsp_err=pslverr and rsp_timeout=0, then go to RESP.
REQ-012 SHALL count consecutive ACCESS cycles with pready=0; when the count reaches TIMEOUT_CYCLES, SHALL go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-013 SHALL clear the wait counter on every entry to SETUP.
REQ-014 SHALL drive psel=0 and penable=0 in IDLE and RESP.
REQ-015 In RESP, SHALL hold rsp_valid=1 and rsp_* stable until rsp_ready=1, then go to IDLE.
REQ-016 SHALL ignore pready, pslverr and prdata outside ACCESS.
REQ-017 Minimum transfer latency: accept to rsp_valid SHALL be 3 cycles (SETUP, one ACCESS, RESP); each pready-low cycle adds one.
REQ-018 Back-to-back: SHALL accept a new command no earlier than the cycle after the rsp_valid && rsp_ready handshake.

Reset
REQ-019 While preset=1 at a pclk edge, SHALL enter IDLE and clear psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout and the wait counter.
REQ-020 Reset during SETUP or ACCESS SHALL abort the transfer with psel=0 on the next cycle and SHALL produce no response.

Structure
REQ-021 The state enum and a response struct (rdata, err, timeout) SHALL live in shared package apb_master_pkg.
REQ-022 The wait/timeout counter SHALL be sub-module apb_wait_timer (inputs clear, enable; output expired).

Verification
REQ-023 Read 0x00: slave gives one wait state, then prdata=0xDEADBEEF, pready=1 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 4 cycles after accept.
REQ-024 Write 0x04 data 0x12345678 -> paddr=0x04, pwdata=0x12345678 stable through SETUP/ACCESS; rsp_err=0, rsp_rdata=0.
REQ-025 Write 0x00, slave answers pslverr=1 -> rsp_err=1, rsp_timeout=0.
REQ-026 pready held low -> after 16 ACCESS cycles psel drops; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-027 rsp_ready low for 5 cycles -> rsp_valid and data held, cmd_ready=0 throughout, then IDLE.
REQ-028 preset asserted in 2nd ACCESS cycle -> next cycle psel=0, rsp_valid=0, cmd_ready=1 after release.
